// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter sharing one multiplexed RTC address/data bus between a refresh reader (A) and a programming writer (B).
// Latency: grant in the request cycle g, done pulse at g+4+2*PHASE_CYC, back in IDLE at g+5+2*PHASE_CYC+GAP_CYC.
// Backpressure: a requester simply holds req until it sees gnt; nothing is queued, and req is ignored while busy.
module rtc_bus_arbiter #(
    parameter int PHASE_CYC = 4,   // strobe low time, 1..15
    parameter int GAP_CYC   = 2    // bus recovery time, 0..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [7:0] addr_a,
    input  logic [7:0] addr_b,
    input  logic [7:0] wdata_a,
    input  logic [7:0] wdata_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       ChipSelect,
    output logic       Read,
    output logic       Write,
    output logic       AoD,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_SET = 3'd1,
        A_STB = 3'd2,
        A_HLD = 3'd3,
        D_SET = 3'd4,
        D_STB = 3'd5,
        D_HLD = 3'd6,
        GAP   = 3'd7
    } state_t;

    // Down-counter reload values; a strobe/gap phase ends when the counter reads zero.
    localparam logic [3:0] PH_LOAD  = 4'(PHASE_CYC - 1);
    localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_grant;

    // Transaction captured at grant; later changes on the request ports are ignored.
    logic       r_sel_b;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_prio_b;   // 1: B wins the next tie (A was served last)

    // Transaction fields as they will be after this edge (fresh capture on a grant).
    logic       w_we_cur;
    logic [7:0] w_addr_cur;
    logic [7:0] w_wdata_cur;

    // Registered bus-side outputs, decoded from the next state so they never glitch.
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_aod;
    logic       r_oe;
    logic [7:0] r_bus;
    logic       r_done_a;
    logic       r_done_b;
    logic       r_busy;
    logic [7:0] r_rdata;

    logic       w_cs_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic       w_aod;
    logic       w_oe;
    logic [7:0] w_bus;
    logic       w_done_a;
    logic       w_done_b;
    logic       w_rd_capture;

    // Next-state, phase counter and round-robin grant decision.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_grant_a  = 1'b0;
        w_grant_b  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_a && (!req_b || !r_prio_b)) begin
                    w_grant_a = 1'b1;
                end else if (req_b) begin
                    w_grant_b = 1'b1;
                end
                if (req_a || req_b) begin
                    w_next = A_SET;
                end
            end
            A_SET: begin
                w_next     = A_STB;
                w_cnt_next = PH_LOAD;
            end
            A_STB: begin
                if (r_cnt == 4'd0) begin
                    w_next = A_HLD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            A_HLD: w_next = D_SET;
            D_SET: begin
                w_next     = D_STB;
                w_cnt_next = PH_LOAD;
            end
            D_STB: begin
                if (r_cnt == 4'd0) begin
                    w_next = D_HLD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            D_HLD: begin
                if (GAP_CYC == 0) begin
                    w_next = IDLE;
                end else begin
                    w_next     = GAP;
                    w_cnt_next = GAP_LOAD;
                end
            end
            GAP: begin
                if (r_cnt == 4'd0) begin
                    w_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_grant      = w_grant_a | w_grant_b;
    assign w_we_cur     = w_grant ? (w_grant_a ? we_a    : we_b)    : r_we;
    assign w_addr_cur   = w_grant ? (w_grant_a ? addr_a  : addr_b)  : r_addr;
    assign w_wdata_cur  = w_grant ? (w_grant_a ? wdata_a : wdata_b) : r_wdata;
    assign w_rd_capture = (r_state == D_STB) && (r_cnt == 4'd0) && !r_we;

    // Decode the strobes and bus drive that belong to the state being entered.
    always_comb begin
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_aod    = 1'b0;
        w_oe     = 1'b0;
        w_bus    = 8'h00;
        w_done_a = 1'b0;
        w_done_b = 1'b0;
        case (w_next)
            A_SET, A_HLD: begin
                w_cs_n = 1'b0;
                w_oe   = 1'b1;
                w_bus  = w_addr_cur;
            end
            A_STB: begin
                w_cs_n = 1'b0;
                w_wr_n = 1'b0;     // address latch strobe
                w_oe   = 1'b1;
                w_bus  = w_addr_cur;
            end
            D_SET, D_HLD: begin
                w_cs_n = 1'b0;
                w_aod  = 1'b1;
                if (w_we_cur) begin
                    w_oe  = 1'b1;
                    w_bus = w_wdata_cur;
                end
                if (w_next == D_HLD) begin
                    w_done_a = !r_sel_b;
                    w_done_b = r_sel_b;
                end
            end
            D_STB: begin
                w_cs_n = 1'b0;
                w_aod  = 1'b1;
                if (w_we_cur) begin
                    w_wr_n = 1'b0;
                    w_oe   = 1'b1;
                    w_bus  = w_wdata_cur;
                end else begin
                    w_rd_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // State, counter, captured transaction and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_sel_b  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_prio_b <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_grant) begin
                r_sel_b  <= w_grant_b;
                r_we     <= w_we_cur;
                r_addr   <= w_addr_cur;
                r_wdata  <= w_wdata_cur;
                r_prio_b <= w_grant_a;
            end
        end
    end

    // Output registers; reset forces the RTC strobes inactive immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_aod    <= 1'b0;
            r_oe     <= 1'b0;
            r_bus    <= 8'h00;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_cs_n   <= w_cs_n;
            r_rd_n   <= w_rd_n;
            r_wr_n   <= w_wr_n;
            r_aod    <= w_aod;
            r_oe     <= w_oe;
            r_bus    <= w_bus;
            r_done_a <= w_done_a;
            r_done_b <= w_done_b;
            r_busy   <= (w_next != IDLE);
        end
    end

    // Read data is sampled at the end of the last data strobe cycle and held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= 8'h00;
        end else if (w_rd_capture) begin
            r_rdata <= bus_in;
        end
    end

    // Grant is a same-cycle pulse; it is masked while reset is held low.
    assign gnt_a      = w_grant_a & reset;
    assign gnt_b      = w_grant_b & reset;
    assign busy       = r_busy | gnt_a | gnt_b;
    assign done_a     = r_done_a;
    assign done_b     = r_done_b;
    assign rdata      = r_rdata;
    assign ChipSelect = r_cs_n;
    assign Read       = r_rd_n;
    assign Write      = r_wr_n;
    assign AoD        = r_aod;
    assign bus_oe     = r_oe;
    assign bus_out    = r_bus;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: per-cycle timeline tables for a write and a read, plus reset,
// round-robin and fast-parameter sequences.
module tb_rtc_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b, we_a, we_b;
    logic [7:0] addr_a, addr_b, wdata_a, wdata_b, bus_in;
    logic       gnt_a, gnt_b, done_a, done_b, busy;
    logic       ChipSelect, Read, Write, AoD, bus_oe;
    logic [7:0] rdata, bus_out;

    // Second instance with the shortest timing.
    logic       f_req_a, f_req_b, f_we_a, f_we_b;
    logic [7:0] f_addr_a, f_addr_b, f_wdata_a, f_wdata_b, f_bus_in;
    logic       f_gnt_a, f_gnt_b, f_done_a, f_done_b, f_busy;
    logic       f_cs, f_rd, f_wr, f_aod, f_oe;
    logic [7:0] f_rdata, f_bus_out;

    always #5 clk = ~clk;

    rtc_bus_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata(rdata), .busy(busy),
        .ChipSelect(ChipSelect), .Read(Read), .Write(Write), .AoD(AoD),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    rtc_bus_arbiter #(.PHASE_CYC(1), .GAP_CYC(0)) u_fast (
        .clk(clk), .reset(reset),
        .req_a(f_req_a), .req_b(f_req_b), .we_a(f_we_a), .we_b(f_we_b),
        .addr_a(f_addr_a), .addr_b(f_addr_b), .wdata_a(f_wdata_a), .wdata_b(f_wdata_b),
        .gnt_a(f_gnt_a), .gnt_b(f_gnt_b), .done_a(f_done_a), .done_b(f_done_b),
        .rdata(f_rdata), .busy(f_busy),
        .ChipSelect(f_cs), .Read(f_rd), .Write(f_wr), .AoD(f_aod),
        .bus_out(f_bus_out), .bus_oe(f_oe), .bus_in(f_bus_in)
    );

    typedef struct {
        logic [7:0]  bus_in;
        logic [25:0] exp;
    } row_t;

    row_t tbl[32];
    int   n_checks = 0;
    int   n_err    = 0;
    int   rw_bad   = 0;

    // Both strobes low together is illegal on either instance.
    always @(negedge clk) begin
        if (!Read && !Write) rw_bad++;
        if (!f_rd && !f_wr) rw_bad++;
    end

    function automatic logic [25:0] mk(input logic ga, gb, da, db, bz, cs, rd, wr, ad, oe,
                                       input logic [7:0] bo, input logic [7:0] rdt);
        return {ga, gb, da, db, bz, cs, rd, wr, ad, oe, bo, rdt};
    endfunction

    function automatic logic [25:0] outs();
        return {gnt_a, gnt_b, done_a, done_b, busy, ChipSelect, Read, Write, AoD, bus_oe, bus_out, rdata};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Starts at posedge+1 with the DUT idle; compares one table row per cycle from the grant cycle.
    task automatic run_txn(input bit use_b, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                           input int base, input string tag);
        if (use_b) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
        end
        for (int off = 0; off < 16; off++) begin
            if (off > 0) begin
                @(posedge clk); #1;
            end
            if (off == 1) begin
                req_a = 1'b0; req_b = 1'b0;
                we_a = ~we; we_b = ~we;
                addr_a = 8'hFF; addr_b = 8'hFF; wdata_a = 8'hEE; wdata_b = 8'hEE;
            end
            bus_in = tbl[base+off].bus_in;
            @(negedge clk);
            chk($sformatf("%s off%0d", tag, off), 32'(outs()), 32'(tbl[base+off].exp));
        end
    endtask

    initial begin
        int   done_cnt;
        int   g_cyc[$];
        bit   g_isb[$];
        int   fg[$];
        int   fd[$];
        logic [7:0] frd[$];

        // Timeline tables: rows 0..15 write by B (0x21/0x45), rows 16..31 read by A (0x22 -> 0x37).
        for (int o = 0; o < 16; o++) begin
            tbl[o].bus_in    = 8'h99;
            tbl[16+o].bus_in = (o >= 8 && o <= 11) ? 8'h37 : 8'h99;
        end
        tbl[0].exp  = mk(0,1,0,0,1, 1,1,1,0,0, 8'h00, 8'h00);
        tbl[1].exp  = mk(0,0,0,0,1, 0,1,1,0,1, 8'h21, 8'h00);
        for (int o = 2; o <= 5; o++) tbl[o].exp = mk(0,0,0,0,1, 0,1,0,0,1, 8'h21, 8'h00);
        tbl[6].exp  = mk(0,0,0,0,1, 0,1,1,0,1, 8'h21, 8'h00);
        tbl[7].exp  = mk(0,0,0,0,1, 0,1,1,1,1, 8'h45, 8'h00);
        for (int o = 8; o <= 11; o++) tbl[o].exp = mk(0,0,0,0,1, 0,1,0,1,1, 8'h45, 8'h00);
        tbl[12].exp = mk(0,0,0,1,1, 0,1,1,1,1, 8'h45, 8'h00);
        tbl[13].exp = mk(0,0,0,0,1, 1,1,1,0,0, 8'h00, 8'h00);
        tbl[14].exp = mk(0,0,0,0,1, 1,1,1,0,0, 8'h00, 8'h00);
        tbl[15].exp = mk(0,0,0,0,0, 1,1,1,0,0, 8'h00, 8'h00);

        tbl[16].exp = mk(1,0,0,0,1, 1,1,1,0,0, 8'h00, 8'h00);
        tbl[17].exp = mk(0,0,0,0,1, 0,1,1,0,1, 8'h22, 8'h00);
        for (int o = 2; o <= 5; o++) tbl[16+o].exp = mk(0,0,0,0,1, 0,1,0,0,1, 8'h22, 8'h00);
        tbl[22].exp = mk(0,0,0,0,1, 0,1,1,0,1, 8'h22, 8'h00);
        tbl[23].exp = mk(0,0,0,0,1, 0,1,1,1,0, 8'h00, 8'h00);
        for (int o = 8; o <= 11; o++) tbl[16+o].exp = mk(0,0,0,0,1, 0,0,1,1,0, 8'h00, 8'h00);
        tbl[28].exp = mk(0,0,1,0,1, 0,1,1,1,0, 8'h00, 8'h37);
        tbl[29].exp = mk(0,0,0,0,1, 1,1,1,0,0, 8'h00, 8'h37);
        tbl[30].exp = mk(0,0,0,0,1, 1,1,1,0,0, 8'h00, 8'h37);
        tbl[31].exp = mk(0,0,0,0,0, 1,1,1,0,0, 8'h00, 8'h37);

        // Reset state, with a request pending that must not be granted.
        reset = 1'b0;
        req_a = 1'b1; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 8'h00; addr_b = 8'h00; wdata_a = 8'h00; wdata_b = 8'h00; bus_in = 8'h99;
        f_req_a = 1'b0; f_req_b = 1'b0; f_we_a = 1'b0; f_we_b = 1'b0;
        f_addr_a = 8'h22; f_addr_b = 8'h00; f_wdata_a = 8'h00; f_wdata_b = 8'h00; f_bus_in = 8'h40;
        repeat (2) @(negedge clk);
        chk("reset outputs", 32'(outs()), 32'(mk(0,0,0,0,0, 1,1,1,0,0, 8'h00, 8'h00)));
        @(posedge clk); #1;
        req_a = 1'b0; reset = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b1, 1'b1, 8'h21, 8'h45, 0, "write_b");
        @(posedge clk); #1;
        run_txn(1'b0, 1'b0, 8'h22, 8'h00, 16, "read_a");
        @(posedge clk); #1;

        // Reset at g+6 of a write by A; the pointer would now favour B but reset returns it to A.
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h30; wdata_a = 8'h31;
        @(negedge clk);
        chk("abort gnt_a", 32'(gnt_a), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 1) req_a = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("abort strobes", 32'(outs()), 32'(mk(0,0,0,0,0, 1,1,1,0,0, 8'h00, 8'h00)));
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            done_cnt += int'(done_a | done_b);
        end
        @(posedge clk); #1;
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("post-reset grant", 32'({gnt_a, gnt_b}), 32'b10);
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            done_cnt += int'(done_a | done_b);
        end
        chk("abort no done", 32'(done_cnt), 32'd0);
        repeat (8) @(posedge clk);
        #1;

        // Round robin with both requests held from reset.
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin
                g_cyc.push_back(c);
                g_isb.push_back(gnt_b);
            end
            if (g_cyc.size() >= 4) break;
            @(posedge clk); #1;
        end
        chk("rr grant count", 32'(g_cyc.size()), 32'd4);
        for (int k = 0; k < g_cyc.size(); k++) begin
            chk($sformatf("rr grant%0d is_b", k), 32'(g_isb[k]), 32'(k % 2));
            chk($sformatf("rr grant%0d cycle", k), 32'(g_cyc[k]), 32'(15 * k));
        end
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        repeat (16) @(posedge clk);
        #1;

        // PHASE_CYC=1, GAP_CYC=0 back-to-back reads; bus_in tags each cycle with 0x40+cycle.
        f_req_a = 1'b1;
        f_bus_in = 8'h40;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (f_gnt_a) fg.push_back(c);
            if (f_done_a) begin
                fd.push_back(c);
                frd.push_back(f_rdata);
            end
            @(posedge clk); #1;
            f_bus_in = 8'h40 + 8'(c + 1);
        end
        f_req_a = 1'b0;
        chk("fast grant count", 32'(fg.size()), 32'd3);
        chk("fast done count", 32'(fd.size()), 32'd2);
        for (int k = 0; k < fg.size(); k++)
            chk($sformatf("fast gnt%0d cycle", k), 32'(fg[k]), 32'(7 * k));
        for (int k = 0; k < fd.size(); k++) begin
            chk($sformatf("fast done%0d cycle", k), 32'(fd[k]), 32'(7 * k + 6));
            chk($sformatf("fast rdata%0d", k), 32'(frd[k]), 32'(8'h45 + 8'(7 * k)));
        end
        repeat (10) @(posedge clk);

        chk("read/write overlap", 32'(rw_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rtc_bus_arbiter.md
RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 Parameter PHASE_CYC, default 4: cycles each strobe is held low; legal range 1..15.
REQ-002 Parameter GAP_CYC, default 2: idle recovery cycles after each transaction; legal range 0..15.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_a, req_b  in  1 each  transaction request; req_a is the display-refresh reader, req_b is the programming writer.
REQ-006 we_a, we_b  in  1 each  1 = write, 0 = read.
REQ-007 addr_a, addr_b  in  8 each  RTC register address.
REQ-008 wdata_a, wdata_b  in  8 each  write data.
REQ-009 gnt_a, gnt_b  out  1 each  one-cycle grant pulse.
REQ-010 done_a, done_b  out  1 each  one-cycle completion pulse.
REQ-011 rdata  out  8  last read data.
REQ-012 busy  out  1  high from grant until return to IDLE.
REQ-013 ChipSelect, Read, Write  out  1 each  active-low RTC strobes.
REQ-014 AoD  out  1  0 = address phase, 1 = data phase.
REQ-015 bus_out  out  8  value driven on the RTC address/data bus.
REQ-016 bus_oe  out  1  1 = drive bus_out.
REQ-017 bus_in  in  8  RTC bus read-back.

Function
REQ-018 The FSM SHALL have states IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP.
REQ-019 In IDLE with any req high, the block SHALL grant one requester, pulse its gnt, and capture its we/addr/wdata in that cycle (cycle g).
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not served last; after reset, A has priority.
REQ-021 Sequence from g+1: A_SET 1 cycle, A_STB PHASE_CYC cycles, A_HLD 1, D_SET 1, D_STB PHASE_CYC cycles, D_HLD 1, GAP GAP_CYC cycles (skipped when 0), then IDLE.
REQ-022 done of the granted requester SHALL be high exactly during D_HLD, i.e. cycle g+4+2*PHASE_CYC.
REQ-023 ChipSelect SHALL be low from A_SET through D_HLD inclusive, high otherwise.
REQ-024 AoD SHALL be 0 in A_SET/A_STB/A_HLD and 1 in D_SET/D_STB/D_HLD; 0 otherwise.
REQ-025 Write SHALL be low during A_STB (address latch) and, for writes, during D_STB.
REQ-026 Read SHALL be low during D_STB for reads only; Read and Write SHALL never be low simultaneously.
REQ-027 bus_out SHALL carry the captured address in the address phase and wdata in the data phase of writes; bus_oe SHALL be 1 in the address phase and in write data phase, 0 otherwise.
REQ-028 For reads, rdata SHALL capture bus_in on the last D_STB cycle and hold until the next read capture.
REQ-029 Dropping req after grant SHALL NOT abort the transaction; done still pulses.
REQ-030 A req held high through done SHALL be treated as a new request at the next IDLE.
REQ-031 Changes to addr/wdata/we after grant SHALL NOT affect the running transaction.

Reset
REQ-032 On reset low, immediately: state IDLE; ChipSelect, Read, Write = 1; AoD, bus_oe, gnt_*, done_*, busy = 0; bus_out, rdata = 0x00; round-robin pointer favours A.
REQ-033 Reset asserted mid-transaction SHALL abort it with no done pulse; after release the first grant follows REQ-019.

Verification
REQ-034 Defaults, req_b write addr 0x21 data 0x45 -> gnt_b at g, Write low g+2..g+5 with bus_out 0x21 AoD 0, Write low g+8..g+11 with bus_out 0x45 AoD 1, done_b at g+12, busy low from g+15.
REQ-035 req_a read addr 0x22, bus_in 0x37 during D_STB -> Read low g+8..g+11, bus_oe 0 there, rdata 0x37 and done_a at g+12.
REQ-036 req_a and req_b both high continuously from reset -> grants alternate A,B,A,B, grants 15 cycles apart.
REQ-037 reset low at g+6 of a write -> all strobes high that cycle, no done, next grant after release.
REQ-038 PHASE_CYC=1, GAP_CYC=0, back-to-back reads -> done at g+6, next gnt at g+7; Read/Write never simultaneously low.
